// File: rtl/dma_bench_msi_arb.sv
// MSI interrupt arbiter: collects per-source event pulses into pending bits,
// picks one unmasked pending source round-robin, issues it as a one-hot MSI
// vector and retries on fail/timeout until the retry budget is spent.
module dma_bench_msi_arb #(
    parameter int IRQ_COUNT   = 32,
    parameter int RETRY_LIMIT = 3,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IRQ_COUNT-1:0] irq_req,
    input  logic [IRQ_COUNT-1:0] irq_mask,
    input  logic [3:0]           cfg_interrupt_msi_enable,
    input  logic [11:0]          cfg_interrupt_msi_mmenable,
    output logic [31:0]          cfg_interrupt_msi_int,
    input  logic                 cfg_interrupt_msi_sent,
    input  logic                 cfg_interrupt_msi_fail,
    output logic [IRQ_COUNT-1:0] irq_pending,
    output logic [31:0]          stat_sent,
    output logic [31:0]          stat_drop
);
    localparam int RW = $clog2(RETRY_LIMIT + 2);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic [IRQ_COUNT-1:0]  pend_r;
    logic [5:0]            rr_ptr_r;
    logic [RW-1:0]         retry_r;
    logic [TW-1:0]         tmo_r;
    logic [4:0]            vec_r;

    logic [63:0]           elig_s;
    logic [63:0]           clr_s;
    logic [6:0]            sum_s;
    logic [5:0]            cand_s;
    logic                  found_s;
    logic [5:0]            sel_idx_s;
    logic [4:0]            sel_vec_s;
    logic                  grant_s;
    logic                  issue_s;
    logic                  retry_inc_s;
    logic                  sent_ev_s;
    logic                  drop_ev_s;
    logic                  unused_cfg_s;

    // Vector = index truncated to the number of allocated vectors (at most 32).
    function automatic logic [4:0] vec_of(input logic [5:0] idx, input logic [2:0] mmen);
        logic [2:0] m;
        logic [5:0] mask;
        m      = (mmen > 3'd5) ? 3'd5 : mmen;
        mask   = (6'd1 << m) - 6'd1;
        vec_of = idx[4:0] & mask[4:0];
    endfunction

    assign unused_cfg_s = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};
    assign sel_vec_s    = vec_of(sel_idx_s, cfg_interrupt_msi_mmenable[2:0]);
    assign clr_s        = grant_s ? (64'd1 << sel_idx_s) : 64'd0;
    assign irq_pending  = pend_r;

    // Round-robin search for the first unmasked pending source from rr_ptr_r.
    always_comb begin
        elig_s                = 64'd0;
        elig_s[IRQ_COUNT-1:0] = pend_r & ~irq_mask;
        found_s               = 1'b0;
        sel_idx_s             = 6'd0;
        sum_s                 = 7'd0;
        cand_s                = 6'd0;
        for (int off = 0; off < IRQ_COUNT; off++) begin
            sum_s  = {1'b0, rr_ptr_r} + 7'(off);
            cand_s = (sum_s >= 7'(IRQ_COUNT)) ? 6'(sum_s - 7'(IRQ_COUNT)) : sum_s[5:0];
            if (!found_s && elig_s[cand_s]) begin
                found_s   = 1'b1;
                sel_idx_s = cand_s;
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Next-state and event decode; sent wins over fail when both are high.
    always_comb begin
        state_nx_s  = state_r;
        grant_s     = 1'b0;
        issue_s     = 1'b0;
        retry_inc_s = 1'b0;
        sent_ev_s   = 1'b0;
        drop_ev_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_interrupt_msi_enable[0] && found_s) begin
                    grant_s    = 1'b1;
                    issue_s    = 1'b1;
                    state_nx_s = ST_REQ;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (cfg_interrupt_msi_sent) begin
                    sent_ev_s  = 1'b1;
                    state_nx_s = ST_IDLE;
                end else if (cfg_interrupt_msi_fail || (tmo_r >= TW'(TIMEOUT - 1))) begin
                    if (retry_r < RW'(RETRY_LIMIT)) begin
                        retry_inc_s = 1'b1;
                        issue_s     = 1'b1;
                        state_nx_s  = ST_REQ;
                    end else begin
                        drop_ev_s   = 1'b1;
                        state_nx_s  = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Pending bits: a new pulse sets its bit even in the cycle the source is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= {IRQ_COUNT{1'b0}};
        end else begin
            pend_r <= (pend_r & ~clr_s[IRQ_COUNT-1:0]) | irq_req;
        end
    end

    // Grant bookkeeping: pointer to the index after the grant, vector and retry count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= 6'd0;
            vec_r    <= 5'd0;
            retry_r  <= {RW{1'b0}};
        end else if (grant_s) begin
            rr_ptr_r <= (sel_idx_s == 6'(IRQ_COUNT - 1)) ? 6'd0 : sel_idx_s + 6'd1;
            vec_r    <= sel_vec_s;
            retry_r  <= {RW{1'b0}};
        end else begin
            rr_ptr_r <= rr_ptr_r;
            vec_r    <= vec_r;
            retry_r  <= retry_inc_s ? retry_r + RW'(1) : retry_r;
        end
    end

    // Timeout counter: zero in the issue cycle, counts through REQ and WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_r <= {TW{1'b0}};
        end else if (issue_s || (state_r == ST_IDLE)) begin
            tmo_r <= {TW{1'b0}};
        end else begin
            tmo_r <= tmo_r + TW'(1);
        end
    end

    // Registered one-hot MSI request, high only in the REQ cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_interrupt_msi_int <= 32'd0;
        end else if (issue_s) begin
            cfg_interrupt_msi_int <= 32'd1 << (grant_s ? sel_vec_s : vec_r);
        end else begin
            cfg_interrupt_msi_int <= 32'd0;
        end
    end

    // Wrapping statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_sent <= 32'd0;
            stat_drop <= 32'd0;
        end else begin
            stat_sent <= sent_ev_s ? stat_sent + 32'd1 : stat_sent;
            stat_drop <= drop_ev_s ? stat_drop + 32'd1 : stat_drop;
        end
    end

endmodule

// File: tb/tb_dma_bench_msi_arb.sv
// Bench for dma_bench_msi_arb: event-level reference model feeds an expected
// MSI queue; a monitor pops and compares whenever a cycle is presented.
module tb_dma_bench_msi_arb;
    localparam int N  = 32;
    localparam int RL = 3;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] irq_req = 32'd0;
    logic [31:0] irq_mask = 32'd0;
    logic [3:0]  en = 4'd0;
    logic [11:0] mmen = 12'd0;
    logic        sent = 1'b0;
    logic        fail = 1'b0;
    logic [31:0] msi_int;
    logic [31:0] pend;
    logic [31:0] st_sent;
    logic [31:0] st_drop;

    dma_bench_msi_arb #(.IRQ_COUNT(N), .RETRY_LIMIT(RL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .irq_mask(irq_mask),
        .cfg_interrupt_msi_enable(en), .cfg_interrupt_msi_mmenable(mmen),
        .cfg_interrupt_msi_int(msi_int), .cfg_interrupt_msi_sent(sent),
        .cfg_interrupt_msi_fail(fail), .irq_pending(pend),
        .stat_sent(st_sent), .stat_drop(st_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int policy = 1;     // 0 random, 1 sent after 3, 2 fail, 3 silent

    // Reference model: phase 0 = no event, 1 = request cycle, 2 = awaiting answer.
    bit [31:0]   m_pend = 32'd0;
    int          m_last = -1;
    int          m_phase = 0;
    int          m_vec = 0;
    int          m_att = 0;
    int          m_wait = 0;
    int          m_mode = 0;
    int          m_delay = 0;
    int unsigned m_sent = 0;
    int unsigned m_drop = 0;
    bit [31:0]   m_elig;
    int          m_m;
    int          m_i;
    bit          m_found;

    typedef struct { int cyc; logic [31:0] val; } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend = 32'd0; m_last = -1; m_phase = 0; m_vec = 0; m_att = 0; m_wait = 0;
        m_sent = 0; m_drop = 0;
        exp_q.delete();
    endtask

    task automatic model_issue();
        exp_t e;
        m_phase = 1;
        m_wait  = 0;
        e.cyc   = cyc + 1;
        e.val   = 32'd1 << m_vec;
        exp_q.push_back(e);
        case (policy)
            0: begin m_mode = $urandom % 4; m_delay = $urandom_range(1, 18); end
            1: begin m_mode = 0; m_delay = 3; end
            2: begin m_mode = 1; m_delay = $urandom_range(1, 5); end
            default: begin m_mode = 3; m_delay = 0; end
        endcase
    endtask

    // Model step per rising edge, using the inputs presented in that cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    m_elig = m_pend & ~irq_mask;
                    if (en[0] && m_elig != 32'd0) begin
                        m_found = 1'b0;
                        for (int k = 1; k <= N; k++) begin
                            m_i = (m_last + k) % N;
                            if (!m_found && m_elig[m_i]) begin
                                m_found = 1'b1;
                                m_last  = m_i;
                            end
                        end
                        m_pend[m_last] = 1'b0;
                        m_m   = (mmen[2:0] > 3'd5) ? 5 : int'(mmen[2:0]);
                        m_vec = m_last % (1 << m_m);
                        m_att = 0;
                        model_issue();
                    end
                end
                1: begin m_phase = 2; m_wait = m_wait + 1; end
                default: begin
                    if (sent) begin
                        m_sent++; m_phase = 0;
                    end else if (fail || m_wait == TO - 1) begin
                        if (m_att < RL) begin m_att++; model_issue(); end
                        else begin m_drop++; m_phase = 0; end
                    end else begin
                        m_wait = m_wait + 1;
                    end
                end
            endcase
            m_pend = m_pend | irq_req;
        end
        cyc++;
    end

    // Responder: answers in WAIT after the chosen delay; random noise elsewhere.
    always @(negedge clk) begin
        if (m_phase == 2 && m_wait == m_delay) begin
            sent = (m_mode == 0 || m_mode == 2);
            fail = (m_mode == 1 || m_mode == 2);
        end else if (m_phase != 2 && policy == 0) begin
            sent = ($urandom % 8 == 0);
            fail = ($urandom % 8 == 0);
        end else begin
            sent = 1'b0;
            fail = 1'b0;
        end
    end

    // Monitor: every cycle compares MSI output against the queue and state against the model.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check("msi_int", msi_int, exp_q[0].val);
            void'(exp_q.pop_front());
        end else begin
            check("msi_int_quiet", msi_int, 32'd0);
        end
        check("irq_pending", pend, m_pend);
        check("stat_sent", st_sent, m_sent);
        check("stat_drop", st_drop, m_drop);
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input logic [31:0] v, output int k);
        step(); irq_req = v; k = cyc;
        step(); irq_req = 32'd0;
    endtask

    task automatic wait_int(input int bound, output logic [31:0] v, output int c);
        v = 32'd0; c = -1;
        for (int i = 0; i < bound; i++) begin
            step();
            if (msi_int != 32'd0) begin v = msi_int; c = cyc; break; end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int          k, c, cnt, d0;
        int          ic[$];

        model_reset();
        idle(3);
        check("rst_int", msi_int, 32'd0);
        check("rst_pend", pend, 32'd0);
        check("rst_sent", st_sent, 32'd0);
        check("rst_drop", st_drop, 32'd0);
        rst_n = 1'b1;
        en = 4'd1; mmen = 12'd5; policy = 1;
        idle(2);

        // Single event on source 5, sent 3 cycles after the request.
        pulse(32'h20, k);
        wait_int(10, v, c);
        check("t1_vector", v, 32'h20);
        check("t1_latency", c, k + 2);
        idle(8);
        check("t1_stat_sent", st_sent, 32'd1);
        check("t1_pending", pend, 32'd0);

        // Round-robin order, then wrap-around from index 4.
        pulse(32'h0000_000E, k);
        wait_int(20, v, c); check("t2_first", v, 32'h2);
        wait_int(20, v, c); check("t2_second", v, 32'h4);
        wait_int(20, v, c); check("t2_third", v, 32'h8);
        idle(10);
        pulse(32'h0000_0005, k);
        wait_int(20, v, c); check("t2_wrap_first", v, 32'h1);
        wait_int(20, v, c); check("t2_wrap_second", v, 32'h4);
        idle(10);
        check("t2_stat_sent", st_sent, 32'd6);

        // Two allocated vectors: source 6 folds onto vector 0.
        mmen = 12'd1;
        pulse(32'h40, k);
        wait_int(10, v, c); check("t3_vector", v, 32'h1);
        idle(10);
        mmen = 12'd5;

        // Persistent fail: one issue plus RL retries, then a drop.
        policy = 2; d0 = st_drop; cnt = 0;
        pulse(32'h80, k);
        for (int i = 0; i < 60; i++) begin step(); if (msi_int != 32'd0) cnt++; end
        check("t4_issues", cnt, RL + 1);
        check("t4_drop", st_drop, d0 + 1);

        // No answer at all: re-issue every TO cycles, then a drop.
        policy = 3; d0 = st_drop; ic.delete();
        pulse(32'h100, k);
        for (int i = 0; i < 90; i++) begin step(); if (msi_int != 32'd0) ic.push_back(cyc); end
        check("t5_issues", ic.size(), RL + 1);
        for (int i = 1; i < ic.size(); i++) check("t5_spacing", ic[i] - ic[i-1], TO);
        check("t5_drop", st_drop, d0 + 1);

        // Masked pending source waits, then issues once after unmask.
        policy = 1; irq_mask = 32'h200; cnt = 0;
        pulse(32'h200, k);
        for (int i = 0; i < 12; i++) begin step(); if (msi_int != 32'd0) cnt++; end
        check("t6_masked_quiet", cnt, 0);
        check("t6_held", pend, 32'h200);
        irq_mask = 32'd0;
        wait_int(10, v, c); check("t6_unmasked", v, 32'h200);
        idle(10);

        // Randomized traffic with mask, enable and vector-count churn.
        policy = 0;
        for (int i = 0; i < 1500; i++) begin
            step();
            irq_req = ($urandom % 4 == 0) ? ($urandom & $urandom & $urandom) : 32'd0;
            if (i % 64 == 0) begin
                irq_mask = $urandom & $urandom;
                en       = 4'($urandom) | 4'(($urandom % 5 != 0) ? 1 : 0);
                en[0]    = ($urandom % 5 != 0);
                mmen     = 12'($urandom);
            end
        end
        step();
        irq_req = 32'd0; irq_mask = 32'd0; en = 4'd1; mmen = 12'd5; policy = 1;
        idle(600);
        check("drain_queue", exp_q.size(), 0);
        check("drain_pending", pend, 32'd0);

        // Reset while waiting for an answer aborts everything immediately.
        policy = 3;
        pulse(32'h10, k);
        wait_int(10, v, c); check("t7_issue", v, 32'h10);
        idle(3);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t7_rst_int", msi_int, 32'd0);
        check("t7_rst_pend", pend, 32'd0);
        check("t7_rst_sent", st_sent, 32'd0);
        check("t7_rst_drop", st_drop, 32'd0);
        idle(2);
        rst_n = 1'b1;
        policy = 1; cnt = 0;
        for (int i = 0; i < 20; i++) begin step(); if (msi_int != 32'd0) cnt++; end
        check("t7_quiet_after", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
